// File: rtl/cmp_lgez_seq.sv
// Multi-cycle wide-word comparator: walks two latched operands MSB-first, one
// p_CHUNK slice per cycle, through CmpLgezNBit and folds the per-slice codes.

module CmpLgezNBit #(
   parameter int p_N    = 4,
   parameter int p_NMOS = 1
) (
   input  logic [p_N-1:0] iv_x,
   input  logic [p_N-1:0] iv_y,
   output logic           o_rx,
   output logic           o_ry
);
   if (p_NMOS != 0 && p_NMOS != 1) begin : g_bad_nmos
      $error("CmpLgezNBit: p_NMOS must be 0 or 1");
   end

   // {rx,ry}: 00 both zero, 11 equal non-zero, 01 x<y, 10 x>y (unsigned)
   always_comb begin
      o_rx = 1'b0;
      o_ry = 1'b0;
      if (iv_x == iv_y) begin
         o_rx = |iv_x;
         o_ry = |iv_x;
      end else if (iv_x < iv_y) begin
         o_ry = 1'b1;
      end else begin
         o_rx = 1'b1;
      end
   end
endmodule

module cmp_lgez_seq #(
   parameter int p_WIDTH      = 16,
   parameter int p_CHUNK      = 4,
   parameter int p_EARLY_EXIT = 0,
   parameter int p_NMOS       = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [p_WIDTH-1:0] iv_x,
   input  logic [p_WIDTH-1:0] iv_y,
   output logic               o_ready,
   output logic               o_busy,
   output logic               o_valid,
   output logic               o_rx,
   output logic               o_ry
);
   if (p_CHUNK < 1 || (p_WIDTH % p_CHUNK) != 0 || p_WIDTH < 1) begin : g_bad_cfg
      $error("cmp_lgez_seq: p_WIDTH must be a positive multiple of p_CHUNK");
   end

   localparam int N  = p_WIDTH / p_CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t                         r_state;
   logic [p_WIDTH-1:0]             r_x, r_y;
   logic [CW-1:0]                  r_cnt;
   logic [1:0]                     r_acc;
   logic                           r_ready, r_busy, r_valid, r_rx, r_ry;

   logic [N-1:0][p_CHUNK-1:0]      w_xs, w_ys;
   logic [p_CHUNK-1:0]             w_xk, w_yk;
   logic                           w_crx, w_cry;
   logic [1:0]                     w_c, w_acc_nxt;
   logic                           w_last;

   assign w_xs = r_x;
   assign w_ys = r_y;
   assign w_xk = w_xs[r_cnt];
   assign w_yk = w_ys[r_cnt];

   CmpLgezNBit #(.p_N(p_CHUNK), .p_NMOS(p_NMOS)) u_cmp (
      .iv_x (w_xk),
      .iv_y (w_yk),
      .o_rx (w_crx),
      .o_ry (w_cry)
   );

   assign w_c = {w_crx, w_cry};

   // A decided 01/10 is sticky; 00 slices never overwrite an earlier 11.
   always_comb begin
      w_acc_nxt = r_acc;
      if (r_acc != 2'b01 && r_acc != 2'b10 && w_c != 2'b00)
         w_acc_nxt = w_c;
   end

   assign w_last = (r_cnt == '0) ||
                   ((p_EARLY_EXIT != 0) && (w_acc_nxt[1] != w_acc_nxt[0]));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_cnt   <= '0;
         r_acc   <= 2'b00;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_rx    <= 1'b0;
         r_ry    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_x     <= iv_x;
                  r_y     <= iv_y;
                  r_acc   <= 2'b00;
                  r_cnt   <= CW'(N - 1);
                  r_state <= S_RUN;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                  r_rx    <= w_acc_nxt[1];
                  r_ry    <= w_acc_nxt[0];
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready = r_ready;
   assign o_busy  = r_busy;
   assign o_valid = r_valid;
   assign o_rx    = r_rx;
   assign o_ry    = r_ry;
endmodule

// File: tb/tb_cmp_lgez_seq.sv
// Bench for cmp_lgez_seq: default fixed, early-exit and exhaustive 6/2 instances,
// scoreboard queues checked by per-instance monitors on the falling edge.

module tb_cmp_lgez_seq;
   typedef struct {
      logic [1:0] code;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_asrt = 0;
   int   n_fail = 0;

   logic        d_start, d_ready, d_busy, d_valid, d_rx, d_ry;
   logic [15:0] d_x, d_y;
   logic        e_start, e_ready, e_busy, e_valid, e_rx, e_ry;
   logic [15:0] e_x, e_y;
   logic        x_start, x_ready, x_busy, x_valid, x_rx, x_ry;
   logic [5:0]  x_x, x_y;
   logic        r_rx, r_ry;

   exp_t q_d[$];
   exp_t q_e[$];
   exp_t q_x[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cmp_lgez_seq #(.p_WIDTH(16), .p_CHUNK(4), .p_EARLY_EXIT(0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(d_start), .iv_x(d_x), .iv_y(d_y),
      .o_ready(d_ready), .o_busy(d_busy), .o_valid(d_valid), .o_rx(d_rx), .o_ry(d_ry));

   cmp_lgez_seq #(.p_WIDTH(16), .p_CHUNK(4), .p_EARLY_EXIT(1)) u_ee (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .iv_x(e_x), .iv_y(e_y),
      .o_ready(e_ready), .o_busy(e_busy), .o_valid(e_valid), .o_rx(e_rx), .o_ry(e_ry));

   cmp_lgez_seq #(.p_WIDTH(6), .p_CHUNK(2), .p_EARLY_EXIT(0)) u_ex (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(x_start), .iv_x(x_x), .iv_y(x_y),
      .o_ready(x_ready), .o_busy(x_busy), .o_valid(x_valid), .o_rx(x_rx), .o_ry(x_ry));

   CmpLgezNBit #(.p_N(6)) u_ref (.iv_x(x_x), .iv_y(x_y), .o_rx(r_rx), .o_ry(r_ry));

   function automatic logic [1:0] model(input logic [15:0] x, input logic [15:0] y);
      if (x == y) return (x == 16'd0) ? 2'b00 : 2'b11;
      return (x < y) ? 2'b01 : 2'b10;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin : mon_d
      exp_t ee;
      if (d_valid) begin
         chk("d_valid_expected", 32'(q_d.size() != 0), 1);
         if (q_d.size() != 0) begin
            ee = q_d.pop_front();
            chk("d_code", {30'd0, d_rx, d_ry}, {30'd0, ee.code});
            chk("d_latency", cyc, ee.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_e
      exp_t ee;
      if (e_valid) begin
         chk("e_valid_expected", 32'(q_e.size() != 0), 1);
         if (q_e.size() != 0) begin
            ee = q_e.pop_front();
            chk("e_code", {30'd0, e_rx, e_ry}, {30'd0, ee.code});
            chk("e_latency", cyc, ee.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_x
      exp_t ee;
      if (x_valid) begin
         chk("x_valid_expected", 32'(q_x.size() != 0), 1);
         if (q_x.size() != 0) begin
            ee = q_x.pop_front();
            chk("x_code", {30'd0, x_rx, x_ry}, {30'd0, ee.code});
            chk("x_latency", cyc, ee.cyc);
         end
      end
   end

   // One operation: pulse start, record expected code and o_valid cycle (m RUN edges),
   // then wait until the instance is back in IDLE.
   task automatic op(input int sel, input logic [15:0] x, input logic [15:0] y,
                     input logic [1:0] code, input int m);
      exp_t ee;
      ee.code = code;
      ee.cyc  = cyc + 1 + m;
      case (sel)
         0: begin d_x = x; d_y = y; d_start = 1'b1; q_d.push_back(ee); end
         1: begin e_x = x; e_y = y; e_start = 1'b1; q_e.push_back(ee); end
         default: begin x_x = x[5:0]; x_y = y[5:0]; x_start = 1'b1; q_x.push_back(ee); end
      endcase
      @(posedge clk); #1;
      d_start = 1'b0; e_start = 1'b0; x_start = 1'b0;
      repeat (m + 1) @(posedge clk);
      #1;
   endtask

   initial begin
      int   k;
      exp_t ee;
      rst_n = 1'b0;
      d_start = 1'b0; d_x = '0; d_y = '0;
      e_start = 1'b0; e_x = '0; e_y = '0;
      x_start = 1'b0; x_x = '0; x_y = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_d", {27'd0, d_ready, d_busy, d_valid, d_rx, d_ry}, 32'b10000);
      chk("rst_e", {27'd0, e_ready, e_busy, e_valid, e_rx, e_ry}, 32'b10000);
      chk("rst_x", {27'd0, x_ready, x_busy, x_valid, x_rx, x_ry}, 32'b10000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fixed-latency directed cases
      op(0, 16'h8000, 16'h0001, 2'b10, 4);
      op(0, 16'h1234, 16'h1234, 2'b11, 4);
      op(0, 16'h0000, 16'h0000, 2'b00, 4);
      op(0, 16'h00FF, 16'h0100, 2'b01, 4);

      // early exit
      op(1, 16'h8000, 16'h0001, 2'b10, 1);
      op(1, 16'h0010, 16'h0011, 2'b01, 4);
      op(1, 16'h1234, 16'h1234, 2'b11, 4);
      op(1, 16'h0000, 16'h0000, 2'b00, 4);
      op(1, 16'h00FF, 16'h0100, 2'b01, 2);

      // reset mid-RUN: previous result on d is 01, must be cleared
      d_x = 16'd5; d_y = 16'd9; d_start = 1'b1;
      @(posedge clk); #1;
      d_start = 1'b0;
      chk("mid_busy", {31'd0, d_busy}, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_outs", {27'd0, d_ready, d_busy, d_valid, d_rx, d_ry}, 32'b10000);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      op(0, 16'd5, 16'd9, 2'b01, 4);

      // i_start held high: one accept per N+2 cycles
      k = cyc;
      d_x = 16'h8000; d_y = 16'h0001; d_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ee.code = 2'b10;
         ee.cyc  = k + 5 + 6 * i;
         q_d.push_back(ee);
      end
      repeat (5) @(posedge clk);
      #1;
      chk("hold_done_ready", {31'd0, d_ready}, 0);
      repeat (12) @(posedge clk);
      #1;
      d_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // operand change while busy, then result persistence
      op(0, 16'h0000, 16'h0000, 2'b00, 4);
      k = cyc;
      d_x = 16'h8000; d_y = 16'h0001; d_start = 1'b1;
      ee.code = 2'b10; ee.cyc = k + 5;
      q_d.push_back(ee);
      @(posedge clk); #1;
      d_start = 1'b0; d_x = 16'h0000; d_y = 16'hFFFF;
      chk("run_ready", {30'd0, d_ready, d_busy}, 32'b01);
      repeat (5) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("persist", {28'd0, d_ready, d_valid, d_rx, d_ry}, 32'b1010);

      // exhaustive 6-bit, 2-bit slices
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            logic [1:0] c;
            c = model(16'(a), 16'(b));
            op(2, 16'(a), 16'(b), c, 3);
            chk("ref6", {30'd0, r_rx, r_ry}, {30'd0, c});
         end
      end

      repeat (4) @(posedge clk);
      #1;
      chk("d_pending", q_d.size(), 0);
      chk("e_pending", q_e.size(), 0);
      chk("x_pending", q_x.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
